// File: rtl/bbox_overlay.sv
// bbox_overlay: gathers the detector's boxes for one frame and, from the next
// frame boundary on, outlines them in BOX_R/G/B on the 2-cycle-delayed stream.
module bbox_overlay #(
    parameter int         MAX_BOXES  = 8,
    parameter int         LINE_WIDTH = 2,
    parameter logic [7:0] BOX_R      = 8'hFF,
    parameter logic [7:0] BOX_G      = 8'h00,
    parameter logic [7:0] BOX_B      = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        de,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [7:0]  r,
    input  logic [7:0]  g,
    input  logic [7:0]  b,
    input  logic        bbox_valid,
    input  logic [15:0] bbox_x_start,
    input  logic [15:0] bbox_y_start,
    input  logic [15:0] bbox_x_end,
    input  logic [15:0] bbox_y_end,
    input  logic        done,
    input  logic        enable,
    output logic        de_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic [7:0]  r_out,
    output logic [7:0]  g_out,
    output logic [7:0]  b_out,
    output logic [3:0]  box_count,
    output logic        overflow
);
    typedef struct packed {
        logic [15:0] xs;
        logic [15:0] ys;
        logic [15:0] xe;
        logic [15:0] ye;
    } box_t;

    localparam logic [16:0] LW   = 17'(LINE_WIDTH);
    localparam logic [3:0]  MAXB = 4'(MAX_BOXES);

    // Widened to 17 bits so that corner + LW never wraps near 65535.
    function automatic logic on_outline(input box_t bx, input logic [15:0] px,
                                        input logic [15:0] py);
        logic [16:0] x, y, xs, ys, xe, ye;
        logic        in_rect, near_edge;
        x  = {1'b0, px};
        y  = {1'b0, py};
        xs = {1'b0, bx.xs};
        ys = {1'b0, bx.ys};
        xe = {1'b0, bx.xe};
        ye = {1'b0, bx.ye};
        in_rect   = (x >= xs) && (x <= xe) && (y >= ys) && (y <= ye);
        near_edge = (x < xs + LW) || (x + LW > xe) || (y < ys + LW) || (y + LW > ye);
        return in_rect && near_edge;
    endfunction

    logic [15:0]                x_q, x_d, y_q, y_d;
    box_t [MAX_BOXES-1:0]       col_q, col_d, dsp_q, dsp_d;
    logic [3:0]                 wr_cnt_q, wr_cnt_d, box_count_q, box_count_d;
    logic                       pend_q, pend_d, ovf_col_q, ovf_col_d;
    logic                       overflow_q, overflow_d;

    logic                       vld_p1_q, vld_p1_d, hs_p1_q, hs_p1_d;
    logic                       vs_p1_q, vs_p1_d, en_p1_q, en_p1_d;
    logic [7:0]                 r_p1_q, r_p1_d, g_p1_q, g_p1_d, b_p1_q, b_p1_d;
    logic [MAX_BOXES-1:0]       hit_p1_q, hit_p1_d;

    logic                       vld_p2_q, vld_p2_d, hs_p2_q, hs_p2_d, vs_p2_q, vs_p2_d;
    logic [7:0]                 r_p2_q, r_p2_d, g_p2_q, g_p2_d, b_p2_q, b_p2_d;

    box_t                       new_box;
    logic                       vs_rise, de_fall, box_ok, box_room, box_wr, box_drop;
    logic                       swap, paint;

    // The stage-1 copies of de/vsync double as the previous-cycle values for edge detection.
    assign vs_rise  = vsync && !vs_p1_q;
    assign de_fall  = !de && vld_p1_q;
    assign new_box  = {bbox_x_start, bbox_y_start, bbox_x_end, bbox_y_end};
    assign box_ok   = (bbox_x_start <= bbox_x_end) && (bbox_y_start <= bbox_y_end);
    assign box_room = !pend_q && (wr_cnt_q < MAXB);
    assign box_wr   = bbox_valid && box_ok && box_room;
    assign box_drop = bbox_valid && box_ok && !box_room;
    assign swap     = vs_rise && (pend_q || done);

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (de) begin
            x_d = x_q + 16'd1;
        end else if (de_fall) begin
            x_d = '0;
        end
        if (vs_rise) begin
            y_d = '0;
        end else if (de_fall) begin
            y_d = y_q + 16'd1;
        end
    end

    // Overflow is tracked per collection and handed to the display side at the
    // swap, so the reported flag stays put for the whole frame it describes.
    always_comb begin
        col_d = col_q;
        for (int i = 0; i < MAX_BOXES; i++) begin
            if (box_wr && (wr_cnt_q == 4'(i))) begin
                col_d[i] = new_box;
            end
        end
        wr_cnt_d    = box_wr ? wr_cnt_q + 4'd1 : wr_cnt_q;
        ovf_col_d   = ovf_col_q | box_drop;
        pend_d      = pend_q | done;
        dsp_d       = dsp_q;
        box_count_d = box_count_q;
        overflow_d  = overflow_q;
        if (swap) begin
            dsp_d       = col_d;
            box_count_d = wr_cnt_d;
            overflow_d  = ovf_col_d;
            wr_cnt_d    = '0;
            ovf_col_d   = 1'b0;
            pend_d      = 1'b0;
        end
    end

    // Stage 1: register video, enable and per-slot hits for the current pixel.
    always_comb begin
        vld_p1_d = de;
        hs_p1_d  = hsync;
        vs_p1_d  = vsync;
        en_p1_d  = enable;
        r_p1_d   = r;
        g_p1_d   = g;
        b_p1_d   = b;
        for (int i = 0; i < MAX_BOXES; i++) begin
            hit_p1_d[i] = (4'(i) < box_count_q) && on_outline(dsp_q[i], x_q, y_q);
        end
    end

    // Stage 2: merge hits and select outline colour or the delayed pixel.
    always_comb begin
        paint    = en_p1_q && vld_p1_q && (|hit_p1_q);
        vld_p2_d = vld_p1_q;
        hs_p2_d  = hs_p1_q;
        vs_p2_d  = vs_p1_q;
        r_p2_d   = paint ? BOX_R : r_p1_q;
        g_p2_d   = paint ? BOX_G : g_p1_q;
        b_p2_d   = paint ? BOX_B : b_p1_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q         <= '0;
            y_q         <= '0;
            col_q       <= '0;
            dsp_q       <= '0;
            wr_cnt_q    <= '0;
            box_count_q <= '0;
            pend_q      <= 1'b0;
            ovf_col_q   <= 1'b0;
            overflow_q  <= 1'b0;
            vld_p1_q    <= 1'b0;
            hs_p1_q     <= 1'b0;
            vs_p1_q     <= 1'b0;
            en_p1_q     <= 1'b0;
            r_p1_q      <= '0;
            g_p1_q      <= '0;
            b_p1_q      <= '0;
            hit_p1_q    <= '0;
            vld_p2_q    <= 1'b0;
            hs_p2_q     <= 1'b0;
            vs_p2_q     <= 1'b0;
            r_p2_q      <= '0;
            g_p2_q      <= '0;
            b_p2_q      <= '0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            col_q       <= col_d;
            dsp_q       <= dsp_d;
            wr_cnt_q    <= wr_cnt_d;
            box_count_q <= box_count_d;
            pend_q      <= pend_d;
            ovf_col_q   <= ovf_col_d;
            overflow_q  <= overflow_d;
            vld_p1_q    <= vld_p1_d;
            hs_p1_q     <= hs_p1_d;
            vs_p1_q     <= vs_p1_d;
            en_p1_q     <= en_p1_d;
            r_p1_q      <= r_p1_d;
            g_p1_q      <= g_p1_d;
            b_p1_q      <= b_p1_d;
            hit_p1_q    <= hit_p1_d;
            vld_p2_q    <= vld_p2_d;
            hs_p2_q     <= hs_p2_d;
            vs_p2_q     <= vs_p2_d;
            r_p2_q      <= r_p2_d;
            g_p2_q      <= g_p2_d;
            b_p2_q      <= b_p2_d;
        end
    end

    assign de_out    = vld_p2_q;
    assign hsync_out = hs_p2_q;
    assign vsync_out = vs_p2_q;
    assign r_out     = r_p2_q;
    assign g_out     = g_p2_q;
    assign b_out     = b_p2_q;
    assign box_count = box_count_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_bbox_overlay.sv
// Bench for bbox_overlay: probe-pixel table plus a frame-level reference model
// compared against every output cycle.
module tb_bbox_overlay;
    localparam int MAXB = 8;
    localparam int LW   = 2;
    localparam logic [7:0] CR = 8'hFF;
    localparam logic [7:0] CG = 8'h00;
    localparam logic [7:0] CB = 8'h00;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        de = 1'b0, hsync = 1'b0, vsync = 1'b0;
    logic [7:0]  r = '0, g = '0, b = '0;
    logic        bbox_valid = 1'b0;
    logic [15:0] bbox_x_start = '0, bbox_y_start = '0, bbox_x_end = '0, bbox_y_end = '0;
    logic        done = 1'b0, enable = 1'b0;
    logic        de_out, hsync_out, vsync_out, overflow;
    logic [7:0]  r_out, g_out, b_out;
    logic [3:0]  box_count;

    always #5 clk = ~clk;

    bbox_overlay #(.MAX_BOXES(MAXB), .LINE_WIDTH(LW), .BOX_R(CR), .BOX_G(CG), .BOX_B(CB)) dut (
        .clk(clk), .reset(reset), .de(de), .hsync(hsync), .vsync(vsync),
        .r(r), .g(g), .b(b), .bbox_valid(bbox_valid),
        .bbox_x_start(bbox_x_start), .bbox_y_start(bbox_y_start),
        .bbox_x_end(bbox_x_end), .bbox_y_end(bbox_y_end),
        .done(done), .enable(enable), .de_out(de_out), .hsync_out(hsync_out),
        .vsync_out(vsync_out), .r_out(r_out), .g_out(g_out), .b_out(b_out),
        .box_count(box_count), .overflow(overflow));

    typedef struct packed {logic [15:0] xs; logic [15:0] ys; logic [15:0] xe; logic [15:0] ye;} box_t;
    typedef struct {bit de; bit hs; bit vs; logic [7:0] r; logic [7:0] g; logic [7:0] b; int x; int y;} exp_t;
    typedef struct {int fr; int x; int y; logic [23:0] rgb;} vec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   pat = 0;
    int   cap_fr = -1;
    logic [23:0] cap [3][64][64];
    vec_t vt [15];

    // reference model state
    box_t col_q[$];
    box_t disp_q[$];
    bit   m_pend = 0, m_col_ovf = 0, m_ovf = 0, m_vs_prev = 0;
    exp_t e_prev;
    bit   e_prev_v = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic box_t mk_box(input int xs, input int ys, input int xe, input int ye);
        box_t bx;
        bx.xs = 16'(xs); bx.ys = 16'(ys); bx.xe = 16'(xe); bx.ye = 16'(ye);
        return bx;
    endfunction

    function automatic box_t rand_box(input bit allow_inv);
        int xs, ys;
        box_t bx;
        xs = int'($urandom_range(0, 34));
        ys = int'($urandom_range(0, 22));
        bx = mk_box(xs, ys, xs + int'($urandom_range(0, 10)), ys + int'($urandom_range(0, 8)));
        if (allow_inv && $urandom_range(0, 7) == 0) bx.xe = 16'(xs - 1 + 65536 * int'(xs == 0));
        return bx;
    endfunction

    function automatic bit on_outline(input box_t bx, input int x, input int y);
        int xs, ys, xe, ye;
        xs = int'(bx.xs); ys = int'(bx.ys); xe = int'(bx.xe); ye = int'(bx.ye);
        if (x < xs || x > xe || y < ys || y > ye) return 0;
        return (x < xs + LW) || (x + LW > xe) || (y < ys + LW) || (y + LW > ye);
    endfunction

    task automatic model_reset();
        col_q.delete(); disp_q.delete();
        m_pend = 0; m_col_ovf = 0; m_ovf = 0; m_vs_prev = 0; e_prev_v = 0;
    endtask

    task automatic model_events();
        box_t bx;
        bx = {bbox_x_start, bbox_y_start, bbox_x_end, bbox_y_end};
        if (bbox_valid && bx.xs <= bx.xe && bx.ys <= bx.ye) begin
            if (m_pend || col_q.size() >= MAXB) m_col_ovf = 1;
            else col_q.push_back(bx);
        end
        if (done) m_pend = 1;
        if (vsync && !m_vs_prev && m_pend) begin
            disp_q = col_q; m_ovf = m_col_ovf;
            col_q.delete(); m_pend = 0; m_col_ovf = 0;
        end
        m_vs_prev = vsync;
    endtask

    // Inputs for this cycle are already applied; outputs seen at this cycle's
    // falling edge belong to the inputs of the previous call.
    task automatic cycle(input int px, input int py);
        exp_t e;
        bit   hit;
        hit = 0;
        foreach (disp_q[i]) if (on_outline(disp_q[i], px, py)) hit = 1;
        e.de = de; e.hs = hsync; e.vs = vsync; e.x = px; e.y = py;
        if (enable && de && hit) begin e.r = CR; e.g = CG; e.b = CB; end
        else begin e.r = r; e.g = g; e.b = b; end
        model_events();
        @(negedge clk);
        if (e_prev_v) begin
            check($sformatf("pix(%0d,%0d)", e_prev.x, e_prev.y),
                  32'({de_out, hsync_out, vsync_out, r_out, g_out, b_out}),
                  32'({e_prev.de, e_prev.hs, e_prev.vs, e_prev.r, e_prev.g, e_prev.b}));
            if (cap_fr >= 0 && e_prev.de && e_prev.x < 64 && e_prev.y < 64)
                cap[cap_fr][e_prev.y][e_prev.x] = {r_out, g_out, b_out};
        end
        e_prev = e;
        e_prev_v = 1;
    endtask

    task automatic set_idle();
        de = 1'b0; hsync = 1'b0; vsync = 1'b0; bbox_valid = 1'b0; done = 1'b0;
        r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
    endtask

    task automatic put_box(input box_t bx);
        bbox_valid = 1'b1;
        bbox_x_start = bx.xs; bbox_y_start = bx.ys; bbox_x_end = bx.xe; bbox_y_end = bx.ye;
    endtask

    task automatic send_box(input box_t bx, input bit d);
        set_idle(); put_box(bx); done = d; cycle(0, 0);
    endtask

    task automatic drive_pix(input int px, input int py);
        de = 1'b1;
        if (pat == 0) begin r = 8'(px); g = 8'(py); b = 8'h5A; end
        else begin r = 8'($urandom); g = 8'($urandom); b = 8'($urandom); end
    endtask

    task automatic aux(input int k, input int ev_at, input box_t ev, input bit ev_done, input bit inject);
        if (k == ev_at) begin
            put_box(ev); done = done | ev_done;
        end else if (inject && $urandom_range(0, 47) == 0) begin
            put_box(rand_box(1));
            if ($urandom_range(0, 3) == 0) done = 1'b1;
        end
    endtask

    task automatic frame(input int w, input int h, input bit dvs, input int ev_at,
                         input box_t ev, input bit ev_done, input bit inject);
        int k;
        k = 0;
        for (int i = 0; i < 4; i++) begin
            set_idle();
            vsync = (i < 2);
            done = dvs && (i == 0);
            aux(k, ev_at, ev, ev_done, inject);
            cycle(0, 0);
            k++;
        end
        for (int yy = 0; yy < h; yy++) begin
            for (int c = 0; c < w + 8; c++) begin
                int px;
                px = 0;
                set_idle();
                hsync = (c < 2);
                if (c >= 6 && c < 6 + w) begin px = c - 6; drive_pix(px, yy); end
                aux(k, ev_at, ev, ev_done, inject);
                cycle(px, yy);
                k++;
            end
        end
        for (int i = 0; i < 2; i++) begin set_idle(); cycle(0, h); end
    endtask

    task automatic frame_plain(input int w, input int h, input bit dvs, input bit inject);
        frame(w, h, dvs, -1, '0, 1'b0, inject);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{0, 10, 15, 24'h0A0F5A};
        vt[1]  = '{0, 20, 20, 24'h14145A};
        vt[2]  = '{1, 10, 15, 24'hFF0000};
        vt[3]  = '{1, 11, 15, 24'hFF0000};
        vt[4]  = '{1, 20, 20, 24'hFF0000};
        vt[5]  = '{1, 19, 10, 24'hFF0000};
        vt[6]  = '{1, 15, 11, 24'hFF0000};
        vt[7]  = '{1, 12, 12, 24'h0C0C5A};
        vt[8]  = '{1,  9, 10, 24'h090A5A};
        vt[9]  = '{1, 21, 15, 24'h150F5A};
        vt[10] = '{2,  0,  0, 24'hFF0000};
        vt[11] = '{2,  1,  1, 24'hFF0000};
        vt[12] = '{2,  1,  0, 24'hFF0000};
        vt[13] = '{2,  2,  1, 24'h02015A};
        vt[14] = '{2,  0,  2, 24'h00025A};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out", 32'({de_out, hsync_out, vsync_out, r_out, g_out, b_out}), 32'd0);
        check("rst_box_count", 32'(box_count), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        set_idle();
        reset = 1'b0;
        model_reset();

        // single box collected during frame 1, drawn from frame 2
        enable = 1'b1; pat = 0;
        cap_fr = 0;
        frame(64, 64, 1'b0, 3, mk_box(10, 10, 20, 20), 1'b1, 1'b0);
        cap_fr = 1;
        frame_plain(64, 64, 1'b0, 1'b0);
        cap_fr = -1;
        check("single_box_count", 32'(box_count), 32'd1);

        // pure pass-through latency with a ramp
        enable = 1'b0;
        frame_plain(32, 24, 1'b0, 1'b0);
        enable = 1'b1;

        // overflow: nine boxes into eight slots
        for (int i = 0; i < 8; i++) send_box(rand_box(0), 1'b0);
        send_box(mk_box(0, 0, 3, 3), 1'b0);
        frame_plain(32, 24, 1'b1, 1'b0);
        check("ovf_box_count", 32'(box_count), 32'd8);
        check("ovf_flag", 32'(overflow), 32'd1);
        frame_plain(32, 24, 1'b1, 1'b0);
        check("ovf_cleared_count", 32'(box_count), 32'd0);
        check("ovf_cleared_flag", 32'(overflow), 32'd0);

        // inverted, tiny and far-right boxes
        send_box(mk_box(5, 5, 4, 9), 1'b0);
        send_box(mk_box(0, 0, 1, 1), 1'b0);
        send_box(mk_box(65530, 0, 65535, 3), 1'b1);
        cap_fr = 2;
        frame_plain(32, 24, 1'b0, 1'b0);
        cap_fr = -1;
        check("edge_box_count", 32'(box_count), 32'd2);
        check("edge_overflow", 32'(overflow), 32'd0);

        // done coinciding with the vsync rise
        send_box(mk_box(3, 3, 12, 9), 1'b0);
        frame_plain(32, 24, 1'b1, 1'b0);
        check("done_at_vs_count", 32'(box_count), 32'd1);

        // box arriving while pending is dropped
        send_box(mk_box(20, 2, 30, 8), 1'b1);
        send_box(mk_box(1, 1, 6, 6), 1'b0);
        frame_plain(32, 24, 1'b0, 1'b0);
        check("pend_drop_count", 32'(box_count), 32'd1);
        check("pend_drop_ovf", 32'(overflow), 32'd1);

        // no done: previous result stays
        frame_plain(32, 24, 1'b0, 1'b0);
        check("hold_count", 32'(box_count), 32'd1);
        check("hold_ovf", 32'(overflow), 32'd1);

        // randomized traffic
        for (int f = 0; f < 6; f++) begin
            enable = 1'($urandom_range(0, 3) != 0);
            pat = int'($urandom_range(0, 1));
            frame_plain(32, 24, 1'($urandom_range(0, 1)), 1'b1);
            check("rand_box_count", 32'(box_count), 32'(disp_q.size()));
            check("rand_overflow", 32'(overflow), 32'(m_ovf));
        end

        // reset mid-frame with three boxes collected and pending
        enable = 1'b1; pat = 1;
        send_box(mk_box(2, 2, 9, 9), 1'b1);
        frame_plain(32, 24, 1'b0, 1'b0);
        send_box(mk_box(1, 1, 5, 5), 1'b0);
        send_box(mk_box(4, 4, 8, 8), 1'b0);
        send_box(mk_box(6, 1, 12, 7), 1'b1);
        for (int c = 0; c < 10; c++) begin
            set_idle(); de = 1'b1; r = 8'hA5; g = 8'h3C; b = 8'h81;
            cycle(c, 24);
        end
        #2;
        reset = 1'b1;
        #1;
        check("midrst_out", 32'({de_out, hsync_out, vsync_out, r_out, g_out, b_out}), 32'd0);
        check("midrst_box_count", 32'(box_count), 32'd0);
        check("midrst_overflow", 32'(overflow), 32'd0);
        set_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        pat = 0;
        frame_plain(32, 24, 1'b0, 1'b0);
        check("post_rst_count", 32'(box_count), 32'd0);

        // probe pixels captured above
        for (int i = 0; i < 15; i++)
            check($sformatf("probe%0d(%0d,%0d)", vt[i].fr, vt[i].x, vt[i].y),
                  32'(cap[vt[i].fr][vt[i].y][vt[i].x]), 32'(vt[i].rgb));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
